// File: rtl/demux2_8_stream_pkg.sv
// Shared constants for the 1-to-2 byte stream demultiplexer:
// widths, destination select encoding and buffer occupancy limits.
package demux2_8_stream_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int CNT_W_DFLT  = 8;
    localparam int DEPTH       = 2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'(DEPTH);

endpackage

// File: rtl/demux2_8_stream_if.sv
// Producer-side and consumer-side stream signals of the demultiplexer,
// with the block itself on the slave modport.
interface demux2_8_stream_if #(
    parameter int DATA_W = demux2_8_stream_pkg::DATA_W_DFLT,
    parameter int CNT_W  = demux2_8_stream_pkg::CNT_W_DFLT
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              demux2_ctr;
    logic              in_ready;
    logic [DATA_W-1:0] a_data;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] b_data;
    logic              b_valid;
    logic              b_ready;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;

    modport slave (
        input  in_data, in_valid, demux2_ctr, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, cnt_a, cnt_b
    );

    modport master (
        output in_data, in_valid, demux2_ctr, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, cnt_a, cnt_b
    );
endinterface

// File: rtl/demux2_8_stream_fifo2_8.sv
// Two-entry registered FIFO; the head is read straight from storage, so a
// pushed word is visible one cycle after its accepting edge.
module fifo2_8
    import demux2_8_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem_r [0:1];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        occ_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Occupancy flags and guarded handshakes; overflow and underflow are ignored.
    always_comb begin
        full      = (occ_r == OCC_FULL);
        empty     = (occ_r == OCC_EMPTY);
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        head_data = mem_r[rd_ptr_r];
    end

    // Storage write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; 1-bit pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= OCC_EMPTY;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule

// File: rtl/demux2_8_stream.sv
// 1-to-2 byte stream demultiplexer: demux2_ctr steers each word into the
// A or B buffer; each consumer drains its own buffer independently.
module demux2_8_stream
    import demux2_8_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int CNT_W  = CNT_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    demux2_8_stream_if.slave  bus
);

    logic             full_a_s;
    logic             full_b_s;
    logic             empty_a_s;
    logic             empty_b_s;
    logic             in_ready_s;
    logic             push_a_s;
    logic             push_b_s;
    logic [CNT_W-1:0] cnt_a_r;
    logic [CNT_W-1:0] cnt_b_r;

    // Readiness depends only on the select and buffer fullness, never on a/b_ready.
    always_comb begin
        case (bus.demux2_ctr)
            SEL_A:   in_ready_s = ~full_a_s;
            SEL_B:   in_ready_s = ~full_b_s;
            default: in_ready_s = 1'b0;
        endcase
        if (bus.in_valid && in_ready_s) begin
            push_a_s = (bus.demux2_ctr == SEL_A);
            push_b_s = (bus.demux2_ctr == SEL_B);
        end else begin
            push_a_s = 1'b0;
            push_b_s = 1'b0;
        end
    end

    fifo2_8 #(.DATA_W(DATA_W)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a_s),
        .push_data (bus.in_data),
        .pop       (bus.a_ready),
        .full      (full_a_s),
        .empty     (empty_a_s),
        .head_data (bus.a_data)
    );

    fifo2_8 #(.DATA_W(DATA_W)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b_s),
        .push_data (bus.in_data),
        .pop       (bus.b_ready),
        .full      (full_b_s),
        .empty     (empty_b_s),
        .head_data (bus.b_data)
    );

    // Accepted-word counters; they wrap silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_r <= '0;
            cnt_b_r <= '0;
        end else begin
            if (push_a_s) begin
                cnt_a_r <= cnt_a_r + CNT_W'(1);
            end
            if (push_b_s) begin
                cnt_b_r <= cnt_b_r + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.a_valid  = ~empty_a_s;
    assign bus.b_valid  = ~empty_b_s;
    assign bus.cnt_a    = cnt_a_r;
    assign bus.cnt_b    = cnt_b_r;

endmodule

// File: tb/tb_demux2_8_stream.sv
// Bench for demux2_8_stream: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_demux2_8_stream;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    bit   run_chk;

    demux2_8_stream_if bus ();

    demux2_8_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] m_cnt_a;
    logic [7:0] m_cnt_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each buffer is a queue of at most two words.
    always @(posedge clk) begin
        logic sel_b;
        logic rdy;
        logic pa;
        logic pb;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
            m_cnt_a = 8'd0;
            m_cnt_b = 8'd0;
        end else begin
            sel_b = bus.demux2_ctr;
            rdy   = sel_b ? (q_b.size() < 2) : (q_a.size() < 2);
            pa    = bus.a_ready && (q_a.size() > 0);
            pb    = bus.b_ready && (q_b.size() > 0);
            if (pa) void'(q_a.pop_front());
            if (pb) void'(q_b.pop_front());
            if (bus.in_valid && rdy) begin
                if (sel_b) begin
                    q_b.push_back(bus.in_data);
                    m_cnt_b = m_cnt_b + 8'd1;
                end else begin
                    q_a.push_back(bus.in_data);
                    m_cnt_a = m_cnt_a + 8'd1;
                end
            end
        end
    end

    // Compare DUT against the model on the falling edge.
    always @(negedge clk) begin
        logic exp_rdy;
        if (rst_n && run_chk) begin
            exp_rdy = bus.demux2_ctr ? (q_b.size() < 2) : (q_a.size() < 2);
            chk("m_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            chk("m_a_valid", 32'(bus.a_valid), 32'(q_a.size() > 0));
            chk("m_b_valid", 32'(bus.b_valid), 32'(q_b.size() > 0));
            if (q_a.size() > 0) chk("m_a_data", 32'(bus.a_data), 32'(q_a[0]));
            if (q_b.size() > 0) chk("m_b_data", 32'(bus.b_data), 32'(q_b[0]));
            chk("m_cnt_a", 32'(bus.cnt_a), 32'(m_cnt_a));
            chk("m_cnt_b", 32'(bus.cnt_b), 32'(m_cnt_b));
        end
    end

    // Apply inputs for one cycle; returns 1 time unit after the next rising edge.
    task automatic drive(input logic v, input logic c, input logic [7:0] d,
                         input logic ar, input logic br);
        bus.in_valid   = v;
        bus.demux2_ctr = c;
        bus.in_data    = d;
        bus.a_ready    = ar;
        bus.b_ready    = br;
        @(posedge clk);
        #1;
    endtask

    // Apply inputs, check in_ready before the edge, then take the edge.
    task automatic offer(input logic c, input logic [7:0] d, input logic ar,
                         input logic br, input logic exp_rdy, input string name);
        bus.in_valid   = 1'b1;
        bus.demux2_ctr = c;
        bus.in_data    = d;
        bus.a_ready    = ar;
        bus.b_ready    = br;
        #2;
        chk(name, 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        run_chk      = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.demux2_ctr = 1'b0;
        bus.in_data    = 8'h00;
        bus.a_ready    = 1'b0;
        bus.b_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        run_chk = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
        chk("rst_a_data", 32'(bus.a_data), 32'h00);
        chk("rst_cnt_a", 32'(bus.cnt_a), 32'd0);
        @(posedge clk);
        #1;

        // Routing
        drive(1'b1, 1'b0, 8'h11, 1'b1, 1'b1);
        chk("route_a11", 32'({bus.a_valid, bus.a_data}), 32'h111);
        drive(1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        chk("route_b22", 32'({bus.b_valid, bus.b_data}), 32'h122);
        chk("route_a_drained", 32'(bus.a_valid), 32'd0);
        drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
        chk("route_a33", 32'({bus.a_valid, bus.a_data}), 32'h133);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("route_cnt_a", 32'(bus.cnt_a), 32'd2);
        chk("route_cnt_b", 32'(bus.cnt_b), 32'd1);

        // Backpressure / full on A, B still accepts
        drive(1'b1, 1'b0, 8'hA1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 8'hA2, 1'b0, 1'b1);
        chk("model_qa_full", 32'(q_a.size()), 32'd2);
        chk("bp_head_a1", 32'(bus.a_data), 32'hA1);
        offer(1'b0, 8'hA3, 1'b0, 1'b1, 1'b0, "bp_full_not_ready");
        offer(1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, "bp_b_ready");
        chk("bp_b1", 32'({bus.b_valid, bus.b_data}), 32'h1B1);
        chk("bp_cnt_a", 32'(bus.cnt_a), 32'd4);

        // Full plus pop: A3 refused, then accepted next cycle
        offer(1'b0, 8'hA3, 1'b1, 1'b1, 1'b0, "fp_refused");
        chk("fp_head_a2", 32'(bus.a_data), 32'hA2);
        chk("fp_cnt_a_hold", 32'(bus.cnt_a), 32'd4);
        offer(1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, "fp_accepted");
        chk("fp_head_a3", 32'({bus.a_valid, bus.a_data}), 32'h1A3);
        chk("fp_cnt_a", 32'(bus.cnt_a), 32'd5);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("fp_a_empty", 32'(bus.a_valid), 32'd0);

        // Simultaneous push and pop at occupancy 1
        drive(1'b1, 1'b0, 8'h77, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 8'h5C, 1'b1, 1'b1);
        chk("pp_head_5c", 32'({bus.a_valid, bus.a_data}), 32'h15C);
        chk("model_qa_one", 32'(q_a.size()), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("pp_occ_one", 32'(bus.a_valid), 32'd0);

        // Mid-stream reset with both buffers loaded
        drive(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mr_loaded", 32'({bus.a_valid, bus.b_valid}), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valids", 32'({bus.a_valid, bus.b_valid}), 32'd0);
        chk("mr_cnts", 32'({bus.cnt_a, bus.cnt_b}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Counter wrap on B
        for (int i = 1; i <= 256; i++) begin
            drive(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
            if (i == 255) chk("wrap_ff", 32'(bus.cnt_b), 32'hFF);
            if (i == 256) chk("wrap_00", 32'(bus.cnt_b), 32'h00);
        end
        chk("wrap_cnt_a", 32'(bus.cnt_a), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

        run_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
